uart_xmit_arbiter: RTL

//  Round-robin scheduler that shares the single UART transmitter (u_xmit) between
//  NUM_REQ byte producers. Grants one requester at a time, drives the transmitter's

---
 rtl/uart_xmit_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/uart_xmit_arbiter.sv
// uart_xmit_arbiter
//   Round-robin scheduler that shares one UART transmitter between NUM_REQ
//   byte producers. It grants one requester at a time, drives the transmitter's
//   xmitH/xmit_dataH start handshake, and follows xmit_doneH to sequence whole
//   frames. A guard gap follows every frame. A transmitter that never starts is
//   flagged with a sticky error, and arbitration then carries on.
//
// Ports
//   sys_clk      in   1          system clock, rising edge
//   sys_rst      in   1          asynchronous active-high reset
//   req_valid    in   NUM_REQ    requester i has a byte pending (held until ack)
//   req_data     in   8*NUM_REQ  byte of requester i in bits [8i+7:8i]
//   req_ack      out  NUM_REQ    one-cycle pulse: byte of requester i accepted
//   xmitH        out  1          one-cycle start pulse to the transmitter
//   xmit_dataH   out  8          granted byte, held until the next grant
//   xmit_doneH   in   1          transmitter idle/done
//   busy         out  1          high whenever the scheduler is not arbitrating
//   grant_id     out  IDW        last/current granted requester
//   err_timeout  out  1          sticky: transmitter failed to start
module uart_xmit_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int IDW        = 2,
    parameter int GAP_CYCLES = 2,
    parameter int START_TO   = 8
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ack,
    output logic                 xmitH,
    output logic [7:0]           xmit_dataH,
    input  logic                 xmit_doneH,
    output logic                 busy,
    output logic [IDW-1:0]       grant_id,
    output logic                 err_timeout
);

    localparam int CNT_MAX = (START_TO > GAP_CYCLES) ? START_TO : GAP_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(START_TO - 1);
    localparam logic [CW-1:0] GAP_LAST = (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;

    typedef enum logic [1:0] {ARB, START_WAIT, DONE_WAIT, GAP} state_e;

    state_e          state_q;
    logic [CW-1:0]   cnt_q;

    logic            win_vld_d;
    logic [IDW-1:0]  win_idx_d;

    // Index of requester 'off' positions after 'base', wrapping at NUM_REQ.
    function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return IDW'(s);
    endfunction

    // Search starts just past the last winner, so the last winner is checked last.
    always_comb begin
        win_vld_d = 1'b0;
        win_idx_d = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!win_vld_d && req_valid[rr_idx(grant_id, i)]) begin
                win_vld_d = 1'b1;
                win_idx_d = rr_idx(grant_id, i);
            end
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q     <= ARB;
            cnt_q       <= '0;
            req_ack     <= '0;
            xmitH       <= 1'b0;
            xmit_dataH  <= '0;
            busy        <= 1'b0;
            grant_id    <= IDW'(NUM_REQ - 1);
            err_timeout <= 1'b0;
        end else begin
            // Ack and start strobe are single-cycle pulses.
            req_ack <= '0;
            xmitH   <= 1'b0;
            case (state_q)
                ARB: begin
                    // Never start a frame while the transmitter is still busy.
                    if (xmit_doneH && win_vld_d) begin
                        grant_id   <= win_idx_d;
                        xmit_dataH <= req_data[{win_idx_d, 3'b000} +: 8];
                        req_ack    <= NUM_REQ'(1) << win_idx_d;
                        xmitH      <= 1'b1;
                        cnt_q      <= '0;
                        busy       <= 1'b1;
                        state_q    <= START_WAIT;
                    end
                end
                START_WAIT: begin
                    if (!xmit_doneH) begin
                        state_q <= DONE_WAIT;
                    end else if (cnt_q == TO_LAST) begin
                        // Transmitter never went busy: drop the frame.
                        err_timeout <= 1'b1;
                        cnt_q       <= '0;
                        if (GAP_CYCLES == 0) begin
                            busy    <= 1'b0;
                            state_q <= ARB;
                        end else begin
                            state_q <= GAP;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE_WAIT: begin
                    if (xmit_doneH) begin
                        cnt_q <= '0;
                        if (GAP_CYCLES == 0) begin
                            busy    <= 1'b0;
                            state_q <= ARB;
                        end else begin
                            state_q <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        busy    <= 1'b0;
                        state_q <= ARB;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    state_q <= ARB;
                end
            endcase
        end
    end

endmodule
